// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
    localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]  state;
    logic [15:0] cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic        nxt_wr;

    assign busy = (state == BUSY);

    // Result datapath: signed divide works on magnitudes so that the
    // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
    always_comb begin
        prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? (32'd0 - A) : A;
        b_mag  = B[31] ? (32'd0 - B) : B;
        sq_mag = 32'd0;
        sr_mag = 32'd0;
        uq     = 32'd0;
        ur     = 32'd0;
        if (B != 32'd0) begin
            sq_mag = a_mag / b_mag;
            sr_mag = a_mag % b_mag;
            uq     = A / B;
            ur     = A % B;
        end
        sq = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
        sr = A[31] ? (32'd0 - sr_mag) : sr_mag;

        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
        nxt_wr = 1'b0;
        case (op)
            OP_MULT:  begin {nxt_hi, nxt_lo} = prod_s; nxt_wr = 1'b1; end
            OP_MULTU: begin {nxt_hi, nxt_lo} = prod_u; nxt_wr = 1'b1; end
            OP_DIV:   begin nxt_hi = sr; nxt_lo = sq; nxt_wr = (B != 32'd0); end
            OP_DIVU:  begin nxt_hi = ur; nxt_lo = uq; nxt_wr = (B != 32'd0); end
            default:  begin nxt_wr = 1'b0; end
        endcase
    end

    // Control FSM, result capture and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                res_hi <= nxt_hi;
                                res_lo <= nxt_lo;
                                res_wr <= nxt_wr;
                                cnt    <= MULT_N;
                                state  <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                res_hi <= nxt_hi;
                                res_lo <= nxt_lo;
                                res_wr <= nxt_wr;
                                cnt    <= DIV_N;
                                state  <= BUSY;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Starts arriving while busy are deliberately ignored.
                    if (cnt <= 16'd1) begin
                        cnt   <= 16'd0;
                        state <= IDLE;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    // Reference model: arithmetic straight from the operation definitions.
    function automatic int model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; return 5; end
            3'd2: begin
                if (y != 0) begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
                return 10;
            end
            3'd3: begin
                if (y != 0) begin m_lo = x / y; m_hi = x % y; end
                return 10;
            end
            3'd4: begin m_hi = x; return 0; end
            3'd5: begin m_lo = x; return 0; end
            default: return 0;
        endcase
    endfunction

    // Issue one op at the current negedge and follow it until busy drops.
    // inject: 0 = quiet, 1 = random starts every busy cycle, 2 = mtlo every busy cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inject, output int cyc, output bit stable);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = x; b = y;
        cyc = 0;
        stable = 1'b1;
        forever begin
            @(negedge clk);
            if (!busy || cyc > 40) break;
            cyc++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            a = $urandom; b = $urandom;
            case (inject)
                1: begin start = 1'b1; op = 3'($urandom_range(0, 7)); end
                2: begin start = 1'b1; op = 3'd5; end
                default: begin start = 1'b0; op = 3'($urandom_range(0, 7)); end
            endcase
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        bit stable;
        int n;
        int k;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd3, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFD, 0};
        vecs[5] = '{3'd5, 32'h00005678, 32'h00000009, 32'h00001234, 32'h00005678, 0};
        vecs[6] = '{3'd6, 32'hAAAAAAAA, 32'h55555555, 32'h00001234, 32'h00005678, 0};
        vecs[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8] = '{3'd0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 5};
        vecs[9] = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // Directed vectors, issued back to back with no idle gap.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, cyc, stable);
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            if (vecs[i].exp_cyc > 0) chk($sformatf("vec%0d_hold", i), 64'(stable), 64'd1);
        end

        // mtlo requested on every busy cycle of a mult, including the last one.
        do_op(3'd0, 32'd7, 32'd9, 2, cyc, stable);
        chk("mtlo_in_busy_cycles", 64'(cyc), 64'd5);
        chk("mtlo_in_busy_hi", 64'(hi), 64'd0);
        chk("mtlo_in_busy_lo", 64'(lo), 64'd63);
        @(negedge clk);
        chk("mtlo_in_busy_after", 64'(lo), 64'd63);

        // Reset on the third busy cycle of a div aborts it.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) k++;
        end
        chk("abort_reached_busy3", 64'(k), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_later_busy", 64'(busy), 64'd0);
        chk("abort_later_hilo", {hi, lo}, 64'd0);

        // Reset and start in the same cycle: start discarded.
        reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h77;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mthi_busy", 64'(busy), 64'd0);
        chk("rst_mthi_hi", 64'(hi), 64'd0);

        // Randomized ops against the reference model.
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            n = model(ro, ra, rb);
            do_op(ro, ra, rb, int'($urandom_range(0, 1)), cyc, stable);
            chk($sformatf("rnd%0d_op%0d_cycles", i, ro), 64'(cyc), 64'(n));
            chk($sformatf("rnd%0d_op%0d_hilo", i, ro), {hi, lo}, {m_hi, m_lo});
            if (n > 0) chk($sformatf("rnd%0d_hold", i), 64'(stable), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
